uart_alu_ctrl: RTL

Sequencing controller between the UART receiver, the combinational ALU and the UART transmitter. It collects three received bytes (operand A, operand B, opcode) from the receiver's done/data interface, drives them onto the ALU, latches the result and hands it to the transmitter with a start pulse. It waits for transmit completion before accepting the next frame. It also provides inter-byte timeout recovery and overrun detection.

---
 rtl/uart_alu_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between UART RX, a combinational ALU and UART TX.
// Collects A, B and opcode bytes, forwards the ALU result to TX and waits for completion.
module uart_alu_ctrl #(
    parameter int NBITS_DATA  = 8,
    parameter int NBITS_OP    = 6,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int NBITS_TO    = 20
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [NBITS_DATA-1:0] i_rx_data,
    input  logic [NBITS_DATA-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [NBITS_DATA-1:0] o_alu_a,
    output logic [NBITS_DATA-1:0] o_alu_b,
    output logic [NBITS_OP-1:0]   o_alu_op,
    output logic [NBITS_DATA-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam logic [NBITS_TO-1:0] TO_LAST = TO_EN ? NBITS_TO'(TIMEOUT_CYC - 1) : '0;

    state_t              state, state_next;
    logic [NBITS_TO-1:0] to_cnt;
    logic                ld_a, ld_b, ld_op, ld_res, to_hit, ovr_set;
    logic                to_term;

    assign to_term = TO_EN && (to_cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // A byte arriving on the terminal count is accepted rather than timed out.
    always_comb begin
        state_next = state;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_op      = 1'b0;
        ld_res     = 1'b0;
        to_hit     = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    ld_a       = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    ld_b       = 1'b1;
                    state_next = WAIT_OP;
                end else if (to_term) begin
                    to_hit     = 1'b1;
                    state_next = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    ld_op      = 1'b1;
                    state_next = EXEC;
                end else if (to_term) begin
                    to_hit     = 1'b1;
                    state_next = WAIT_A;
                end
            end
            EXEC: begin
                ld_res     = 1'b1;
                ovr_set    = i_rx_done;
                state_next = SEND;
            end
            SEND: begin
                ovr_set    = i_rx_done;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                ovr_set = i_rx_done;
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (ld_a)    o_alu_a   <= i_rx_data;
            if (ld_b)    o_alu_b   <= i_rx_data;
            if (ld_op)   o_alu_op  <= i_rx_data[NBITS_OP-1:0];
            if (ld_res)  o_tx_data <= i_alu_result;
            if (ovr_set) o_overrun <= 1'b1;
        end
    end

    // Counter measures the gap since the last accepted byte of a partial frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            to_cnt <= '0;
        end else if (ld_a || ld_b || ld_op || state_next == WAIT_A) begin
            to_cnt <= '0;
        end else if (TO_EN && (state == WAIT_B || state == WAIT_OP)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign o_tx_start = (state == SEND);
    assign o_busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
    assign o_timeout  = to_hit;

endmodule
